vid_packet_encode: RTL and testbench
====================================

VID_PACKET_ENCODE -- requirements
Module: vid_packet_encode

Interface
REQ-001 Parameter DATA_WIDTH, default 10, symbol width in bits; legal range 4 to 32.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 din_data  input  DATA_WIDTH  raw pixel symbol.
REQ-005 din_valid  input  1  pixel beat valid.
REQ-006 din_ready  output  1  pixel beat accepted when din_valid && din_ready.
REQ-007 din_startofpacket  input  1  first pixel of a frame.
REQ-008 din_endofpacket  input  1  last pixel of a frame.
REQ-009 video_width  input  16  frame width, sampled at frame start.
REQ-010 video_height  input  16  frame height, sampled at frame start.
REQ-011 video_interlaced  input  4  interlace nibble, sampled at frame start.
REQ-012 dout_data  output  DATA_WIDTH  Avalon-ST video symbol.
REQ-013 dout_valid  output  1  output beat valid.
REQ-014 dout_ready  input  1  downstream ready; a beat transfers when dout_valid && dout_ready.
REQ-015 dout_startofpacket  output  1  first beat of a packet.
REQ-016 dout_endofpacket  output  1  last beat of a packet.

Function
REQ-017 States SHALL be IDLE, CTRL, VHDR and DATA, with a 4-bit beat counter used in CTRL.
REQ-018 All dout_* SHALL be registered.
REQ-019 The output register SHALL load only when load_en = !dout_valid || dout_ready, and SHALL hold all dout_* stable otherwise.
REQ-020 In IDLE, din_ready SHALL equal !din_startofpacket, so stray non-SOP beats are consumed and discarded; no output is produced for them.
REQ-021 IDLE to CTRL: when din_valid && din_startofpacket, latch video_width, video_height and video_interlaced, and clear the counter; the SOP beat itself is not consumed.
REQ-022 CTRL SHALL emit 10 beats, one per load_en cycle. Upper data bits are zero on every beat; the listed value goes in dout_data[3:0].
- beat 0: 0xF, with SOP=1.
- beats 1-4: width[15:12], width[11:8], width[7:4], width[3:0].
- beats 5-8: the same nibble order for height.
- beat 9: interlaced[3:0], with EOP=1.
REQ-023 After CTRL beat 9 loads, the state SHALL go to VHDR.
REQ-024 VHDR SHALL emit one beat with data 0x0, SOP=1, EOP=0, then go to DATA.
REQ-025 In DATA, din_ready SHALL equal load_en.
REQ-026 Each accepted DATA beat SHALL load dout_data=din_data, SOP=0, EOP=din_endofpacket, dout_valid=1.
REQ-027 An accepted beat with din_endofpacket=1 SHALL return the state to IDLE.
REQ-028 din_startofpacket asserted in DATA SHALL be ignored; the beat is forwarded as an ordinary pixel.
REQ-029 In CTRL and VHDR, din_ready SHALL be 0.
REQ-030 When load_en=1 and no beat is available (DATA with !din_valid, or IDLE), dout_valid SHALL go to 0.
REQ-031 Latency: first control beat valid 1 cycle after SOP is presented in IDLE; a pixel accepted in DATA appears on dout the next cycle.
REQ-032 With dout_ready held at 1 continuously, there SHALL be no bubbles between CTRL, VHDR and DATA beats.
REQ-033 Latched parameters SHALL NOT change mid-frame even if the video_* inputs change.

Reset
REQ-034 While rst=1, the block SHALL hold: state IDLE, counter 0, latched params 0, dout_valid=0, dout_data=0, dout_startofpacket=0, dout_endofpacket=0, din_ready=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately with no EOP emitted; after release the block waits for a new SOP.

Verification
REQ-036 Width 640, height 480, interlaced 0, dout_ready=1, SOP pixel 0x155 -> dout sequence 0xF(SOP),0,2,8,0,0,1,E,0,0(EOP),0x0(SOP),0x155.
REQ-037 Frame of 4 pixels 1,2,3,4 with EOP on 4 -> dout 1,2,3,4, EOP only on 4; state back to IDLE, din_ready=0 while the next SOP is pending.
REQ-038 dout_ready toggles 1/0 every cycle during CTRL -> each beat held stable while not ready; the 10 control beats appear in order with none lost or duplicated.
REQ-039 Non-SOP beats 0x3FF,0x001 in IDLE -> both consumed (din_ready=1), dout_valid stays 0.
REQ-040 rst pulsed during the DATA beat at pixel 2 -> dout_valid=0 asynchronously; the next SOP produces a full control packet with the newly sampled dimensions.
REQ-041 video_width changed from 640 to 800 during DATA -> the next frame's control packet carries 800 nibbles 0,3,2,0; the current frame is unaffected.

Source files
------------

// File: rtl/vid_packet_encode_if.sv
// Stream bundle for the video packet encoder: raw pixel input and Avalon-ST video output.
// master is the encoder side, slave is the upstream/downstream environment side.
interface vid_packet_encode_if #(
  parameter int DATA_WIDTH = 10
) ();
  logic [DATA_WIDTH-1:0] din_data;
  logic                  din_valid;
  logic                  din_ready;
  logic                  din_startofpacket;
  logic                  din_endofpacket;
  logic [DATA_WIDTH-1:0] dout_data;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_startofpacket;
  logic                  dout_endofpacket;

  modport master (
    input  din_data, din_valid, din_startofpacket, din_endofpacket, dout_ready,
    output din_ready, dout_data, dout_valid, dout_startofpacket, dout_endofpacket
  );

  modport slave (
    output din_data, din_valid, din_startofpacket, din_endofpacket, dout_ready,
    input  din_ready, dout_data, dout_valid, dout_startofpacket, dout_endofpacket
  );
endinterface

// File: rtl/vid_packet_encode.sv
// Wraps each raw pixel frame as a 10-beat control packet, a video header beat and
// the pixel stream, with a single registered output stage under dout_ready backpressure.
module vid_packet_encode #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          video_width,
  input  logic [15:0]          video_height,
  input  logic [3:0]           video_interlaced,
  vid_packet_encode_if.master  vif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CTRL = 2'd1;
  localparam logic [1:0] VHDR = 2'd2;
  localparam logic [1:0] DATA = 2'd3;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [15:0]           width_q;
  logic [15:0]           height_q;
  logic [3:0]            intl_q;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_p0;
  logic                  sop_p0;
  logic                  eop_p0;
  logic                  load_en;
  logic                  din_ready_c;

  function automatic logic [3:0] ctrl_nibble(input logic [3:0]  beat,
                                             input logic [15:0] w,
                                             input logic [15:0] h,
                                             input logic [3:0]  il);
    logic [3:0] n;
    case (beat)
      4'd0:    n = 4'hF;
      4'd1:    n = w[15:12];
      4'd2:    n = w[11:8];
      4'd3:    n = w[7:4];
      4'd4:    n = w[3:0];
      4'd5:    n = h[15:12];
      4'd6:    n = h[11:8];
      4'd7:    n = h[7:4];
      4'd8:    n = h[3:0];
      4'd9:    n = il;
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pad_nibble(input logic [3:0] n);
    logic [DATA_WIDTH-1:0] r;
    r      = '0;
    r[3:0] = n;
    return r;
  endfunction

  assign load_en = !vld_p0 || vif.dout_ready;

  // The SOP beat is left waiting in IDLE so it becomes the first pixel of DATA.
  always_comb begin
    din_ready_c = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    din_ready_c = !vif.din_startofpacket;
        DATA:    din_ready_c = load_en;
        default: din_ready_c = 1'b0;
      endcase
    end
  end

  // p0: output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      width_q  <= 16'd0;
      height_q <= 16'd0;
      intl_q   <= 4'd0;
      data_p0  <= '0;
      vld_p0   <= 1'b0;
      sop_p0   <= 1'b0;
      eop_p0   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) vld_p0 <= 1'b0;
          if (vif.din_valid && vif.din_startofpacket) begin
            width_q  <= video_width;
            height_q <= video_height;
            intl_q   <= video_interlaced;
            cnt      <= 4'd0;
            state    <= CTRL;
          end
        end
        CTRL: begin
          if (load_en) begin
            vld_p0  <= 1'b1;
            data_p0 <= pad_nibble(ctrl_nibble(cnt, width_q, height_q, intl_q));
            sop_p0  <= (cnt == 4'd0);
            eop_p0  <= (cnt == 4'd9);
            if (cnt == 4'd9) begin
              cnt   <= 4'd0;
              state <= VHDR;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        VHDR: begin
          if (load_en) begin
            vld_p0  <= 1'b1;
            data_p0 <= '0;
            sop_p0  <= 1'b1;
            eop_p0  <= 1'b0;
            state   <= DATA;
          end
        end
        default: begin
          if (load_en) begin
            if (vif.din_valid) begin
              vld_p0  <= 1'b1;
              data_p0 <= vif.din_data;
              sop_p0  <= 1'b0;
              eop_p0  <= vif.din_endofpacket;
              if (vif.din_endofpacket) state <= IDLE;
            end else begin
              vld_p0 <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign vif.din_ready          = din_ready_c;
  assign vif.dout_data          = data_p0;
  assign vif.dout_valid         = vld_p0;
  assign vif.dout_startofpacket = sop_p0;
  assign vif.dout_endofpacket   = eop_p0;

endmodule

// File: tb/tb_vid_packet_encode.sv
// Randomized bench for vid_packet_encode: frames are expanded into the expected
// output beat list by a stream-level model and compared beat by beat on transfer.
module tb_vid_packet_encode;
  localparam int DW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] video_width;
  logic [15:0] video_height;
  logic [3:0]  video_interlaced;

  vid_packet_encode_if #(.DATA_WIDTH(DW)) vif ();

  vid_packet_encode #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .video_width      (video_width),
    .video_height     (video_height),
    .video_interlaced (video_interlaced),
    .vif              (vif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    int            kind;   // 1: first control beat, 2: first pixel
  } beat_t;

  beat_t         expq[$];
  logic [DW-1:0] pix_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random
  int            t_ctrl0 = 0;
  int            t_pix0 = 0;
  int            cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected output of one frame, from the packet format rules.
  task automatic model_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
    beat_t      b;
    logic [3:0] nib[10];
    nib[0] = 4'hF;
    for (int k = 0; k < 4; k++) begin
      nib[1+k] = 4'((w >> (12 - 4*k)) % 16);
      nib[5+k] = 4'((h >> (12 - 4*k)) % 16);
    end
    nib[9] = il;
    for (int k = 0; k < 10; k++) begin
      b.data = DW'(nib[k]); b.sop = (k == 0); b.eop = (k == 9); b.kind = (k == 0) ? 1 : 0;
      expq.push_back(b);
    end
    b.data = '0; b.sop = 1'b1; b.eop = 1'b0; b.kind = 0;
    expq.push_back(b);
    for (int p = 0; p < pix_q.size(); p++) begin
      b.data = pix_q[p]; b.sop = 1'b0; b.eop = (p == pix_q.size() - 1); b.kind = (p == 0) ? 2 : 0;
      expq.push_back(b);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       vif.dout_ready = 1'b1;
      1:       vif.dout_ready = !vif.dout_ready;
      default: vif.dout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic        hold = 1'b0;
  logic [63:0] held;
  logic [63:0] cur;
  beat_t       e;

  always @(negedge clk) begin
    cyc++;
    cur = 64'({vif.dout_valid, vif.dout_startofpacket, vif.dout_endofpacket, vif.dout_data});
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) check("hold_stable", cur, held);
      if (vif.dout_valid && vif.dout_ready) begin
        if (expq.size() == 0) begin
          check("beat_expected", 64'(expq.size()), 64'd1);
        end else begin
          e = expq.pop_front();
          check("beat", 64'({vif.dout_startofpacket, vif.dout_endofpacket, vif.dout_data}),
                64'({e.sop, e.eop, e.data}));
          if (e.kind == 1) t_ctrl0 = cyc;
          if (e.kind == 2) t_pix0 = cyc;
        end
      end
      hold = vif.dout_valid && !vif.dout_ready;
      held = cur;
    end
  end

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic send_beat(output bit ok);
    bit hs;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      hs = vif.din_valid && vif.din_ready;
      @(posedge clk); #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("handshake_timeout", 64'd0, 64'd1);
      finish_run();
    end
  endtask

  task automatic fill_random(input int n);
    pix_q.delete();
    repeat (n) pix_q.push_back(DW'($urandom));
  endtask

  task automatic send_frame(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                            input bit rnd, input bit change_mid, input int abort_at);
    bit ok;
    video_width = w; video_height = h; video_interlaced = il;
    model_frame(w, h, il);
    for (int p = 0; p < pix_q.size(); p++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 2)) begin
          vif.din_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      vif.din_data          = pix_q[p];
      vif.din_valid         = 1'b1;
      vif.din_startofpacket = (p == 0) || (rnd && $urandom_range(0, 7) == 0);
      vif.din_endofpacket   = (p == pix_q.size() - 1);
      if (p == 0) begin
        @(negedge clk);
        check("sop_pending_ready", 64'(vif.din_ready), 64'd0);
      end
      send_beat(ok);
      if (p == 0 && change_mid) begin
        video_width      = 16'd800;
        video_height     = 16'($urandom);
        video_interlaced = 4'($urandom);
      end
      if (p == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("abort_dout_valid", 64'(vif.dout_valid), 64'd0);
        check("abort_dout_eop", 64'(vif.dout_endofpacket), 64'd0);
        check("abort_din_ready", 64'(vif.din_ready), 64'd0);
        expq.delete();
        vif.din_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    vif.din_valid = 1'b0;
  endtask

  task automatic send_stray(input logic [DW-1:0] d);
    bit ok;
    vif.din_data          = d;
    vif.din_valid         = 1'b1;
    vif.din_startofpacket = 1'b0;
    vif.din_endofpacket   = 1'($urandom);
    @(negedge clk);
    check("stray_ready", 64'(vif.din_ready), 64'd1);
    send_beat(ok);
    vif.din_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && expq.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ab;
    rst = 1'b1;
    vif.din_valid = 1'b0; vif.din_startofpacket = 1'b0; vif.din_endofpacket = 1'b0;
    vif.din_data = '0;
    video_width = '0; video_height = '0; video_interlaced = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", 64'(vif.dout_valid), 64'd0);
    check("rst_dout_data", 64'(vif.dout_data), 64'd0);
    check("rst_dout_sop", 64'(vif.dout_startofpacket), 64'd0);
    check("rst_dout_eop", 64'(vif.dout_endofpacket), 64'd0);
    check("rst_din_ready", 64'(vif.din_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 640x480 progressive, continuous ready: header then pixels with no gaps
    pix_q.delete(); pix_q.push_back(DW'(10'h155)); pix_q.push_back(DW'(10'h0AA));
    send_frame(16'd640, 16'd480, 4'd0, 1'b0, 1'b0, -1);
    drain();
    check("no_bubble_gap", 64'(t_pix0 - t_ctrl0), 64'd11);

    pix_q.delete();
    for (int i = 1; i <= 4; i++) pix_q.push_back(DW'(i));
    send_frame(16'd640, 16'd480, 4'd0, 1'b0, 1'b0, -1);
    drain();

    send_stray(DW'(10'h3FF));
    send_stray(DW'(10'h001));
    repeat (2) @(posedge clk);
    #1;
    check("stray_no_output", 64'(vif.dout_valid), 64'd0);

    rdy_mode = 1;
    fill_random(3);
    send_frame(16'd1920, 16'd1080, 4'hA, 1'b0, 1'b0, -1);
    drain();

    rdy_mode = 0;
    fill_random(5);
    send_frame(16'd640, 16'd480, 4'd0, 1'b0, 1'b0, 1);
    fill_random(2);
    send_frame(16'd320, 16'd240, 4'h2, 1'b0, 1'b0, -1);
    drain();

    fill_random(4);
    send_frame(16'd640, 16'd480, 4'd0, 1'b0, 1'b1, -1);
    fill_random(2);
    send_frame(16'd800, 16'd600, 4'd0, 1'b0, 1'b0, -1);
    drain();

    for (int f = 0; f < 30; f++) begin
      rdy_mode = $urandom_range(0, 2);
      n = $urandom_range(1, 12);
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      fill_random(n);
      send_frame(16'($urandom), 16'($urandom), 4'($urandom), 1'b1, 1'($urandom_range(0, 1)), ab);
      repeat ($urandom_range(0, 2)) send_stray(DW'($urandom));
    end
    rdy_mode = 0;
    drain();
    finish_run();
  end
endmodule
